axi_wr_burst_gate: RTL and testbench
====================================

// Module: axi_wr_burst_gate
// PURPOSE
//  Write-address scheduler placed beside the write-data FIFO of an AXI4 FIFO path. Holds each
//  accepted AW in a one-entry register and releases it downstream only when its full burst is buffered
//  (counted WLAST beats) and a write-response credit is free. AW payload is opaque; the data path is untouched.
// PARAMETERS
//  AW_PAYLOAD_W  64  opaque AW fields (id/addr/size/burst/...) carried with awlen
//  FIFO_DEPTH    32  beats the write-data FIFO holds; bursts with awlen+1 > FIFO_DEPTH bypass the data gate
//  MAX_OUTST     16  max AWs issued and awaiting B (1..255)
//  CNT_W         8   width of burst-credit counter magnitude (signed counter is CNT_W+1 bits)
// PORTS
//  clk            in   1             clock
//  rst_n          in   1             async reset, active low
//  s_awvalid      in   1             upstream AW valid
//  s_awready      out  1             upstream AW ready
//  s_awlen        in   8             burst length-1
//  s_awpayload    in   AW_PAYLOAD_W  other AW fields
//  m_awvalid      out  1             downstream AW valid
//  m_awready      in   1             downstream AW ready
//  m_awlen        out  8             held awlen
//  m_awpayload    out  AW_PAYLOAD_W  held payload
//  w_in_last      in   1             pulse: beat with WLAST written into data FIFO
//  b_done         in   1             pulse: B handshake completed downstream (bvalid&bready)
//  outst_cnt      out  8             AWs issued awaiting B
// BEHAVIOUR
//  Reset (async assert, sync deassert externally): state EMPTY, m_awvalid=0, s_awready=0 while rst_n=0,
//   credit=0, outst_cnt=0, m_awlen/m_awpayload=0.
//  FSM: EMPTY -> WAIT on s_awvalid&s_awready (capture len/payload).
//   WAIT -> ISSUE when go = (credit>0 || s_awlen_held+1 > FIFO_DEPTH) && outst_cnt < MAX_OUTST.
//   ISSUE -> EMPTY on m_awready; ISSUE -> WAIT same cycle if new AW also accepted (back-to-back).
//  s_awready = (state==EMPTY) | (state==ISSUE & m_awready). Latency: AW accepted cycle N -> earliest m_awvalid N+2
//   (N+1 evaluates go, registered into ISSUE).
//  m_awvalid = (state==ISSUE), registered; once high it stays high until m_awready (AXI stability), payload stable.
//  Reservation at WAIT->ISSUE: credit -= 1, outst_cnt += 1. Events same cycle are summed:
//   credit += w_in_last - reserve; outst_cnt += reserve - b_done (net 0 when both).
//  credit is signed CNT_W+1: bypassed long bursts drive it negative until their WLAST arrives; saturate at
//   +2^CNT_W-1 (w_in_last ignored at max, assertion fires). b_done with outst_cnt==0 ignored + assertion.
//  No transactions dropped or reordered; AW order == upstream order.
// CONFIGURATION
//  `AXI_WR_BURST_GATE_STATS_EN defined: adds outputs stat_stall_cycles[31:0] (cycles in WAIT with go=0)
//   and stat_bursts[31:0] (AW handshakes downstream), both saturating, reset 0, clear input stat_clr (sync).
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Shared package axi_fifo_pkg: gate state enum (EMPTY/WAIT/ISSUE), AXI len width constant (8).
//  One sub-module: axi_gate_credit_cnt (signed up/down saturating counter, reused for credit; outst_cnt
//   uses same with unsigned clamp). Everything else flat in this module.
// TESTING
//  1 AW len=3, no w_in_last -> m_awvalid stays 0 100 cycles; pulse w_in_last -> m_awvalid=1 two cycles later.
//  2 FIFO_DEPTH=32, AW len=63 with credit 0 -> issues without waiting; credit=-1; later w_in_last -> 0.
//  3 MAX_OUTST=2, 3 buffered bursts, no b_done -> 2 issue, 3rd held in WAIT; b_done -> 3rd issues.
//  4 w_in_last and reserve same cycle with credit=1 -> credit stays 1; b_done + reserve -> outst_cnt unchanged.
//  5 m_awready held low 10 cycles in ISSUE -> m_awvalid, m_awlen, payload stable throughout; rst_n low mid-ISSUE
//   -> m_awvalid drops immediately, counters 0.
//  6 STATS_EN: 4 stall cycles then issue -> stat_stall_cycles=4, stat_bursts=1; stat_clr -> both 0.

Source files
------------

// File: rtl/axi_wr_burst_gate_pkg.sv
// Shared types and constants for the AXI write-burst gate (package axi_fifo_pkg).
package axi_fifo_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  typedef logic [1:0] gate_state_t;
  localparam gate_state_t GATE_EMPTY = 2'd0;
  localparam gate_state_t GATE_WAIT  = 2'd1;
  localparam gate_state_t GATE_ISSUE = 2'd2;

  // Long bursts cannot ever be fully buffered, so they skip the data gate.
  function automatic logic exceeds_fifo(input logic [AXI_LEN_W-1:0] len,
                                        input int unsigned depth);
    return (32'(len) + 32'd1) > depth;
  endfunction

endpackage

// File: rtl/axi_wr_burst_gate_if.sv
// AXI write-address channel bundle (valid/ready/len plus opaque payload).
interface axi_wr_burst_gate_if
  import axi_fifo_pkg::*;
#(
  parameter int unsigned AW_PAYLOAD_W = 64
);
  logic                    awvalid;
  logic                    awready;
  logic [AXI_LEN_W-1:0]    awlen;
  logic [AW_PAYLOAD_W-1:0] awpayload;

  modport master (output awvalid, awlen, awpayload, input awready);
  modport slave  (input awvalid, awlen, awpayload, output awready);
endinterface

// File: rtl/axi_wr_burst_gate_credit_cnt.sv
// Up/down counter of CNT_W+1 bits that ignores steps past its clamp limits;
// signed range (credit) or unsigned range (outstanding count) by CLAMP_ZERO.
module axi_gate_credit_cnt #(
  parameter int unsigned CNT_W      = 8,
  parameter bit          CLAMP_ZERO = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_inc,
  input  logic           i_dec,
  output logic [CNT_W:0] o_cnt
);
  localparam int unsigned    W       = CNT_W + 1;
  localparam logic [CNT_W:0] CNT_MAX = CLAMP_ZERO ? {W{1'b1}} : {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] CNT_MIN = CLAMP_ZERO ? {W{1'b0}} : {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE     = W'(1);

  logic [CNT_W:0] r_cnt;
  logic           w_at_max;
  logic           w_at_min;

  assign w_at_max = (r_cnt == CNT_MAX);
  assign w_at_min = (r_cnt == CNT_MIN);
  assign o_cnt    = r_cnt;

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !w_at_max) begin
      r_cnt <= r_cnt + ONE;
    end else if (i_dec && !i_inc && !w_at_min) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                   !(i_inc && !i_dec && w_at_max));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(i_dec && !i_inc && w_at_min));

endmodule

// File: rtl/axi_wr_burst_gate.sv
// Holds one AW and releases it once its burst is buffered and a B credit is free.
// Optional statistics counters enabled by `AXI_WR_BURST_GATE_STATS_EN.
module axi_wr_burst_gate
  import axi_fifo_pkg::*;
#(
  parameter int unsigned AW_PAYLOAD_W = 64,
  parameter int unsigned FIFO_DEPTH   = 32,
  parameter int unsigned MAX_OUTST    = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_wr_burst_gate_if.slave   s_aw,
  axi_wr_burst_gate_if.master  m_aw,
  input  logic                 w_in_last,
  input  logic                 b_done,
`ifdef AXI_WR_BURST_GATE_STATS_EN
  input  logic                 stat_clr,
  output logic [31:0]          stat_stall_cycles,
  output logic [31:0]          stat_bursts,
`endif
  output logic [AXI_LEN_W-1:0] outst_cnt
);
  localparam logic [AXI_LEN_W-1:0] OUTST_LIMIT = AXI_LEN_W'(MAX_OUTST);

  gate_state_t             r_state;
  gate_state_t             w_state_nxt;
  logic [AXI_LEN_W-1:0]    r_awlen;
  logic [AW_PAYLOAD_W-1:0] r_awpayload;
  logic [CNT_W:0]          w_credit;
  logic [AXI_LEN_W-1:0]    w_outst;
  logic                    w_s_awready;
  logic                    w_accept;
  logic                    w_credit_pos;
  logic                    w_go;
  logic                    w_reserve;

  assign w_s_awready  = rst_n && ((r_state == GATE_EMPTY) ||
                                  ((r_state == GATE_ISSUE) && m_aw.awready));
  assign w_accept     = s_aw.awvalid && w_s_awready;
  assign w_credit_pos = !w_credit[CNT_W] && (|w_credit);
  assign w_go         = (w_credit_pos || exceeds_fifo(r_awlen, FIFO_DEPTH)) &&
                        (w_outst < OUTST_LIMIT);
  assign w_reserve    = (r_state == GATE_WAIT) && w_go;

  assign s_aw.awready   = w_s_awready;
  assign m_aw.awvalid   = (r_state == GATE_ISSUE);
  assign m_aw.awlen     = r_awlen;
  assign m_aw.awpayload = r_awpayload;
  assign outst_cnt      = w_outst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= GATE_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // ISSUE may hand straight back to WAIT when a new AW lands on the release cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      GATE_EMPTY: if (w_accept) w_state_nxt = GATE_WAIT;
      GATE_WAIT:  if (w_go)     w_state_nxt = GATE_ISSUE;
      GATE_ISSUE: if (m_aw.awready) w_state_nxt = w_accept ? GATE_WAIT : GATE_EMPTY;
      default:    w_state_nxt = GATE_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awlen     <= '0;
      r_awpayload <= '0;
    end else if (w_accept) begin
      r_awlen     <= s_aw.awlen;
      r_awpayload <= s_aw.awpayload;
    end
  end

  axi_gate_credit_cnt #(.CNT_W(CNT_W), .CLAMP_ZERO(1'b0)) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_in_last),
    .i_dec (w_reserve),
    .o_cnt (w_credit)
  );

  axi_gate_credit_cnt #(.CNT_W(AXI_LEN_W - 1), .CLAMP_ZERO(1'b1)) u_outst (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_reserve),
    .i_dec (b_done),
    .o_cnt (w_outst)
  );

`ifdef AXI_WR_BURST_GATE_STATS_EN
  logic [31:0] r_stall;
  logic [31:0] r_bursts;

  assign stat_stall_cycles = r_stall;
  assign stat_bursts       = r_bursts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall  <= '0;
      r_bursts <= '0;
    end else if (stat_clr) begin
      r_stall  <= '0;
      r_bursts <= '0;
    end else begin
      if ((r_state == GATE_WAIT) && !w_go && (r_stall != '1)) r_stall <= r_stall + 32'd1;
      if (m_aw.awvalid && m_aw.awready && (r_bursts != '1))   r_bursts <= r_bursts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_burst_gate.sv
// Scoreboard bench for axi_wr_burst_gate: expected AWs queued at upstream accept,
// checked by a monitor at each downstream handshake.
module tb_axi_wr_burst_gate;
  import axi_fifo_pkg::*;

  localparam int unsigned PW = 64;

  typedef struct {
    logic [7:0]    len;
    logic [PW-1:0] pl;
  } aw_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_in_last = 1'b0;
  logic       b_done = 1'b0;
  logic [7:0] outst_cnt;
`ifdef AXI_WR_BURST_GATE_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_bursts;
`endif

  axi_wr_burst_gate_if #(.AW_PAYLOAD_W(PW)) s_aw ();
  axi_wr_burst_gate_if #(.AW_PAYLOAD_W(PW)) m_aw ();

  axi_wr_burst_gate #(
    .AW_PAYLOAD_W (PW),
    .FIFO_DEPTH   (32),
    .MAX_OUTST    (2),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_aw      (s_aw),
    .m_aw      (m_aw),
    .w_in_last (w_in_last),
    .b_done    (b_done),
`ifdef AXI_WR_BURST_GATE_STATS_EN
    .stat_clr          (stat_clr),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_bursts       (stat_bursts),
`endif
    .outst_cnt (outst_cnt)
  );

  always #5 clk = ~clk;

  aw_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: a downstream handshake happens at the next posedge.
  always @(negedge clk) begin
    aw_t e;
    if (rst_n && m_aw.awvalid && m_aw.awready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_aw: got len %0d, required no AW", m_aw.awlen);
      end else begin
        e = exp_q.pop_front();
        chk("aw_len", 64'(m_aw.awlen), 64'(e.len));
        chk("aw_payload", 64'(m_aw.awpayload), 64'(e.pl));
      end
    end
  end

  task automatic send_aw(input logic [7:0] l, input logic [PW-1:0] p);
    int t;
    aw_t e;
    @(negedge clk);
    s_aw.awvalid = 1'b1;
    s_aw.awlen = l;
    s_aw.awpayload = p;
    t = 0;
    while (!s_aw.awready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_aw.awready) begin
      n_checks++;
      n_fail++;
      $display("FAIL aw_accept_timeout: got awready 0, required 1 within 50 cycles");
      s_aw.awvalid = 1'b0;
    end else begin
      e.len = l;
      e.pl = p;
      exp_q.push_back(e);
      @(posedge clk);
      #1 s_aw.awvalid = 1'b0;
    end
  endtask

  task automatic pulse_wlast();
    @(negedge clk) w_in_last = 1'b1;
    @(negedge clk) w_in_last = 1'b0;
  endtask

  task automatic pulse_bdone();
    @(negedge clk) b_done = 1'b1;
    @(negedge clk) b_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic hold_low(input int n, input string name);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (m_aw.awvalid) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  initial begin
    int bad_v;
    int bad_l;
    int bad_p;
    s_aw.awvalid = 1'b0;
    s_aw.awlen = '0;
    s_aw.awpayload = '0;
    m_aw.awready = 1'b1;

    // Reset state
    #12;
    chk("rst_m_awvalid", 64'(m_aw.awvalid), 64'd0);
    chk("rst_s_awready", 64'(s_aw.awready), 64'd0);
    chk("rst_outst", 64'(outst_cnt), 64'd0);
    chk("rst_m_awlen", 64'(m_aw.awlen), 64'd0);
    chk("rst_m_payload", 64'(m_aw.awpayload), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_s_awready", 64'(s_aw.awready), 64'd1);

    // 1: short burst waits for its WLAST, then issues two cycles after it
    send_aw(8'd3, 64'h0000_0000_0000_00A1);
    hold_low(100, "t1_hold_no_wlast");
    @(negedge clk) w_in_last = 1'b1;
    @(negedge clk) w_in_last = 1'b0;
    chk("t1_valid_plus1", 64'(m_aw.awvalid), 64'd0);
    @(negedge clk);
    chk("t1_valid_plus2", 64'(m_aw.awvalid), 64'd1);
    wait_drain("t1_drain");
    chk("t1_outst", 64'(outst_cnt), 64'd1);
    pulse_bdone();
    chk("t1_outst_bdone", 64'(outst_cnt), 64'd0);

    // 2: long burst bypasses the gate and leaves credit at -1
    send_aw(8'd63, 64'hB2B2_0000_0000_0002);
    @(negedge clk);
    @(negedge clk);
    chk("t2_bypass_issue", 64'(m_aw.awvalid), 64'd1);
    wait_drain("t2_drain_long");
    pulse_bdone();
    send_aw(8'd1, 64'h0000_C3C3_0000_0003);
    pulse_wlast();
    hold_low(10, "t2_credit_back_to_zero");
    pulse_wlast();
    wait_drain("t2_drain_short");
    pulse_bdone();
    chk("t2_outst", 64'(outst_cnt), 64'd0);

    // 3: outstanding limit of 2 holds the third burst
    repeat (3) pulse_wlast();
    send_aw(8'd0, 64'hD1);
    send_aw(8'd0, 64'hD2);
    send_aw(8'd0, 64'hD3);
    hold_low(10, "t3_third_held");
    chk("t3_outst_full", 64'(outst_cnt), 64'd2);
    chk("t3_pending", 64'(exp_q.size()), 64'd1);
    pulse_bdone();
    wait_drain("t3_drain");
    chk("t3_outst_refill", 64'(outst_cnt), 64'd2);
    pulse_bdone();
    pulse_bdone();
    chk("t3_outst_empty", 64'(outst_cnt), 64'd0);

    // 4: w_in_last with reserve keeps credit at 1; b_done with reserve keeps outst
    pulse_wlast();
    send_aw(8'd0, 64'hE1);
    @(negedge clk) w_in_last = 1'b1;
    @(negedge clk) w_in_last = 1'b0;
    wait_drain("t4_drain_e1");
    pulse_bdone();
    send_aw(8'd0, 64'hE2);
    wait_drain("t4_credit_one_used");
    chk("t4_outst_e2", 64'(outst_cnt), 64'd1);
    send_aw(8'd0, 64'hE3);
    hold_low(10, "t4_credit_exhausted");
    pulse_wlast();
    wait_drain("t4_drain_e3");
    pulse_bdone();
    chk("t4_outst_one", 64'(outst_cnt), 64'd1);
    pulse_wlast();
    send_aw(8'd0, 64'hE4);
    @(negedge clk) b_done = 1'b1;
    @(negedge clk) b_done = 1'b0;
    chk("t4_outst_net_zero", 64'(outst_cnt), 64'd1);
    wait_drain("t4_drain_e4");
    pulse_bdone();
    chk("t4_outst_end", 64'(outst_cnt), 64'd0);

    // 5: stall in ISSUE keeps everything stable; reset mid-ISSUE clears it
    m_aw.awready = 1'b0;
    pulse_wlast();
    send_aw(8'd7, 64'hF5F5_F5F5_0123_4567);
    @(negedge clk);
    @(negedge clk);
    bad_v = 0;
    bad_l = 0;
    bad_p = 0;
    repeat (10) begin
      if (m_aw.awvalid !== 1'b1) bad_v++;
      if (m_aw.awlen !== 8'd7) bad_l++;
      if (m_aw.awpayload !== 64'hF5F5_F5F5_0123_4567) bad_p++;
      @(negedge clk);
    end
    chk("t5_valid_stable", 64'(bad_v), 64'd0);
    chk("t5_len_stable", 64'(bad_l), 64'd0);
    chk("t5_payload_stable", 64'(bad_p), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(m_aw.awvalid), 64'd0);
    chk("t5_rst_outst", 64'(outst_cnt), 64'd0);
    chk("t5_rst_s_awready", 64'(s_aw.awready), 64'd0);
    chk("t5_rst_len", 64'(m_aw.awlen), 64'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    m_aw.awready = 1'b1;
    send_aw(8'd0, 64'hF6);
    hold_low(5, "t5_credit_cleared");
    pulse_wlast();
    wait_drain("t5_drain");
    pulse_bdone();
    chk("t5_outst_end", 64'(outst_cnt), 64'd0);

`ifdef AXI_WR_BURST_GATE_STATS_EN
    // 6: four stall cycles, one burst, then clear
    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
    chk("t6_clr_stall", 64'(stat_stall_cycles), 64'd0);
    send_aw(8'd0, 64'h51);
    repeat (3) @(negedge clk);
    pulse_wlast();
    wait_drain("t6_drain");
    chk("t6_stall_cycles", 64'(stat_stall_cycles), 64'd4);
    chk("t6_bursts", 64'(stat_bursts), 64'd1);
    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
    chk("t6_clr_stall_after", 64'(stat_stall_cycles), 64'd0);
    chk("t6_clr_bursts_after", 64'(stat_bursts), 64'd0);
    pulse_bdone();
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
